// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video blocks:
//   - COLORDEPTH_DEFAULT : default pixel width
//   - NUM_BARS           : number of colour bars in the bar pattern
//   - state_t            : run-control state machine encoding
//   - pat_t              : pattern-select encoding (matches pat_sel_i values)
//   - cnt_width()        : counter width for a 0..total-1 counter
//   - bar_width()        : pixels per colour bar (never less than 1)
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int COLORDEPTH_DEFAULT = 8;
    localparam int NUM_BARS           = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SOLID   = 2'd3
    } pat_t;

    // Width of a counter that runs 0..total-1; a degenerate total still
    // gets one bit so that vectors stay legal.
    function automatic int cnt_width(input int total);
        if (total > 1) begin
            return $clog2(total);
        end
        return 1;
    endfunction

    // Pixels per colour bar; tiny test rasters still get one pixel per bar.
    function automatic int bar_width(input int h_active);
        if ((h_active / NUM_BARS) < 1) begin
            return 1;
        end
        return h_active / NUM_BARS;
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// -----------------------------------------------------------------------------
// video_timing_cnt
// Raster position counters plus the combinational decode of the timing
// strobes. Line and frame order are: active, front porch, sync, back porch.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cnt_en       : 1 = advance the raster, 0 = hold counters at 0,0
//   hcnt, vcnt   : current pixel / line position
//   dv           : position lies inside the active window
//   hs           : horizontal sync interval (every line, blanking included)
//   vs           : vertical sync lines
//   line_end     : last active pixel of an active line
//   frame_start  : first active pixel of the frame
//   h_last       : last pixel of the line (hcnt == H_TOTAL-1)
//   frame_last   : last pixel of the frame
// -----------------------------------------------------------------------------
module video_timing_cnt
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1600,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 80,
    parameter int H_BP     = 96,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 96,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_width(H_TOTAL),
    localparam int VW      = cnt_width(V_TOTAL)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cnt_en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          dv,
    output logic          hs,
    output logic          vs,
    output logic          line_end,
    output logic          frame_start,
    output logic          h_last,
    output logic          frame_last
);

    logic [HW-1:0] hcnt_reg;
    logic [VW-1:0] vcnt_reg;
    logic          v_last;
    logic          h_act;
    logic          v_act;

    // Comparisons are done on 32-bit zero-extended copies so the integer
    // timing parameters compare without width games.
    assign h_last = (32'(hcnt_reg) == H_TOTAL - 1);
    assign v_last = (32'(vcnt_reg) == V_TOTAL - 1);
    assign h_act  = (32'(hcnt_reg) < H_ACTIVE);
    assign v_act  = (32'(vcnt_reg) < V_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst || !cnt_en) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (h_last) begin
            hcnt_reg <= '0;
            vcnt_reg <= v_last ? '0 : vcnt_reg + VW'(1);
        end else begin
            hcnt_reg <= hcnt_reg + HW'(1);
        end
    end

    assign hcnt        = hcnt_reg;
    assign vcnt        = vcnt_reg;
    assign frame_last  = h_last && v_last;
    assign dv          = h_act && v_act;
    assign hs          = (32'(hcnt_reg) >= H_ACTIVE + H_FP) &&
                         (32'(hcnt_reg) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs          = (32'(vcnt_reg) >= V_ACTIVE + V_FP) &&
                         (32'(vcnt_reg) <  V_ACTIVE + V_FP + V_SYNC);
    assign line_end    = dv && (32'(hcnt_reg) == H_ACTIVE - 1);
    assign frame_start = dv && (hcnt_reg == '0) && (vcnt_reg == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
// Test-pattern video source with run control. A timing sub-block walks the
// raster; this block selects the pixel pattern and registers every output so
// all of them carry the same one-cycle latency from the counter state.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en_i           : run request (a frame in progress always completes)
//   pat_sel_i      : 0 bars, 1 ramp, 2 checker, 3 solid (sampled at frame start)
//   solid_i        : solid-fill value (sampled at frame start)
//   data_o         : pixel value, 0 outside the active window
//   dv_o           : data valid
//   hs_o, vs_o     : active-high syncs
//   line_end_o     : last active pixel of a line
//   frame_start_o  : first active pixel of a frame
//   busy_o         : raster running (RUN or DRAIN)
// -----------------------------------------------------------------------------
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int COLORDEPTH = COLORDEPTH_DEFAULT,
    parameter int H_ACTIVE   = 1600,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 80,
    parameter int H_BP       = 96,
    parameter int V_ACTIVE   = 900,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 96
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [1:0]            pat_sel_i,
    input  logic [COLORDEPTH-1:0] solid_i,
    output logic [COLORDEPTH-1:0] data_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  line_end_o,
    output logic                  frame_start_o,
    output logic                  busy_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int BAR_W   = bar_width(H_ACTIVE);
    localparam int BCW     = cnt_width(BAR_W);

    // ------------------------------------------------------------------
    // Raster timing
    // ------------------------------------------------------------------
    logic [HW-1:0] t_hcnt;
    logic [VW-1:0] t_vcnt;
    logic          t_dv;
    logic          t_hs;
    logic          t_vs;
    logic          t_line_end;
    logic          t_frame_start;
    logic          t_h_last;
    logic          t_frame_last;
    logic          cnt_active;

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .cnt_en      (cnt_active),
        .hcnt        (t_hcnt),
        .vcnt        (t_vcnt),
        .dv          (t_dv),
        .hs          (t_hs),
        .vs          (t_vs),
        .line_end    (t_line_end),
        .frame_start (t_frame_start),
        .h_last      (t_h_last),
        .frame_last  (t_frame_last)
    );

    // ------------------------------------------------------------------
    // Run-control state machine
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN lets the current frame finish; re-requesting run while draining
    // returns to RUN without touching the counters, so frames stay seamless.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (en_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en_i) begin
                    state_next = ST_RUN;
                end else if (t_frame_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The raster advances in RUN and DRAIN; in IDLE the counters sit at 0,0
    // so the first cycle after leaving IDLE is the first pixel of a frame.
    always_comb begin
        cnt_active = (state_reg != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Pattern selection, captured once per frame
    // ------------------------------------------------------------------
    logic                  frame_origin;
    pat_t                  pat_reg;
    logic [COLORDEPTH-1:0] solid_reg;
    pat_t                  pat_cur;
    logic [COLORDEPTH-1:0] solid_cur;

    assign frame_origin = (t_hcnt == '0) && (t_vcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg   <= PAT_BARS;
            solid_reg <= '0;
        end else if (frame_origin) begin
            pat_reg   <= pat_t'(pat_sel_i);
            solid_reg <= solid_i;
        end
    end

    // The first pixel of a frame already uses the value being captured, so
    // the inputs are bypassed at the origin.
    assign pat_cur   = frame_origin ? pat_t'(pat_sel_i) : pat_reg;
    assign solid_cur = frame_origin ? solid_i : solid_reg;

    // ------------------------------------------------------------------
    // Colour-bar tracking: a pixel counter within the bar plus a bar index,
    // both cleared at the start of every line.
    // ------------------------------------------------------------------
    logic [BCW-1:0] bar_cnt_reg;
    logic [2:0]     bar_idx_reg;

    always_ff @(posedge clk) begin
        if (rst || !cnt_active || t_h_last) begin
            bar_cnt_reg <= '0;
            bar_idx_reg <= '0;
        end else if (t_dv) begin
            if (bar_cnt_reg == BCW'(BAR_W - 1)) begin
                bar_cnt_reg <= '0;
                // Any remainder pixels of H_ACTIVE/8 stay in the last bar.
                if (bar_idx_reg != 3'(NUM_BARS - 1)) begin
                    bar_idx_reg <= bar_idx_reg + 3'd1;
                end
            end else begin
                bar_cnt_reg <= bar_cnt_reg + BCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Ramp and checker sources. Counters narrower than the referenced bit
    // positions contribute zeros.
    // ------------------------------------------------------------------
    logic [COLORDEPTH-1:0] ramp_pix;
    logic                  h_bit4;
    logic                  v_bit4;

    genvar gi;
    generate
        for (gi = 0; gi < COLORDEPTH; gi++) begin : g_ramp
            if (gi < HW) begin : g_bit
                assign ramp_pix[gi] = t_hcnt[gi];
            end else begin : g_zero
                assign ramp_pix[gi] = 1'b0;
            end
        end

        if (HW > 4) begin : g_hbit
            assign h_bit4 = t_hcnt[4];
        end else begin : g_hbit_zero
            assign h_bit4 = 1'b0;
        end

        if (VW > 4) begin : g_vbit
            assign v_bit4 = t_vcnt[4];
        end else begin : g_vbit_zero
            assign v_bit4 = 1'b0;
        end
    endgenerate

    logic [COLORDEPTH-1:0] pix;

    always_comb begin
        pix = '0;
        case (pat_cur)
            PAT_BARS:    pix = COLORDEPTH'(bar_idx_reg) << (COLORDEPTH - 3);
            PAT_RAMP:    pix = ramp_pix;
            PAT_CHECKER: pix = {COLORDEPTH{h_bit4 ^ v_bit4}};
            PAT_SOLID:   pix = solid_cur;
            default:     pix = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage: everything is sampled from the same counter
    // state, so all outputs stay mutually aligned.
    // ------------------------------------------------------------------
    logic [COLORDEPTH-1:0] data_reg;
    logic                  dv_reg;
    logic                  hs_reg;
    logic                  vs_reg;
    logic                  line_end_reg;
    logic                  frame_start_reg;
    logic                  busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg        <= '0;
            dv_reg          <= 1'b0;
            hs_reg          <= 1'b0;
            vs_reg          <= 1'b0;
            line_end_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            data_reg        <= (cnt_active && t_dv) ? pix : '0;
            dv_reg          <= cnt_active && t_dv;
            hs_reg          <= cnt_active && t_hs;
            vs_reg          <= cnt_active && t_vs;
            line_end_reg    <= cnt_active && t_line_end;
            frame_start_reg <= cnt_active && t_frame_start;
            busy_reg        <= cnt_active;
        end
    end

    assign data_o        = data_reg;
    assign dv_o          = dv_reg;
    assign hs_o          = hs_reg;
    assign vs_o          = vs_reg;
    assign line_end_o    = line_end_reg;
    assign frame_start_o = frame_start_reg;
    assign busy_o        = busy_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
// Small raster (14 x 7). A behavioural model predicts the registered outputs
// of every cycle; predictions are queued when the inputs are driven and
// compared after the clock edge. A vector table adds fixed expected first
// lines per pattern, and hand sequences cover mid-frame pattern change,
// drain, re-run during drain and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;   // 14
    localparam int VT = VA + VFP + VS + VBP;   // 7
    localparam int FRAME = HT * VT;            // 98

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic [1:0] pat_sel_i;
    logic [7:0] solid_i;
    logic [7:0] data_o;
    logic       dv_o, hs_o, vs_o, line_end_o, frame_start_o, busy_o;

    video_pattern_gen #(
        .COLORDEPTH (8),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .pat_sel_i     (pat_sel_i),
        .solid_i       (solid_i),
        .data_o        (data_o),
        .dv_o          (dv_o),
        .hs_o          (hs_o),
        .vs_o          (vs_o),
        .line_end_o    (line_end_o),
        .frame_start_o (frame_start_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic dv, hs, vs, le, fs, busy;
    } obs_t;

    typedef struct packed {
        logic [1:0]  pat;
        logic [7:0]  solid;
        logic [63:0] row;      // expected first active line, pixel k in [8k+7:8k]
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[4];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model state: 0 idle, 1 run, 2 drain
    int         m_state = 0;
    int         mh = 0, mv = 0;
    logic [1:0] m_pat = 2'd0;
    logic [7:0] m_solid = 8'd0;

    // per-frame statistics
    int n_dv, n_hs, n_vs, n_fs, n_le, n_5a, n_zero;
    int dv_first, hs_first, row_n;
    int last_fs_cyc = -1000;
    int fs_gap = 0;
    logic [7:0] row [8];

    function automatic obs_t model_out();
        obs_t o;
        logic [1:0] p;
        logic [7:0] s;
        o = '0;
        if (!rst && m_state != 0) begin
            o.busy = 1'b1;
            o.dv = (mh < HA) && (mv < VA);
            o.hs = (mh >= HA + HFP) && (mh < HA + HFP + HS);
            o.vs = (mv >= VA + VFP) && (mv < VA + VFP + VS);
            o.le = o.dv && (mh == HA - 1);
            o.fs = o.dv && (mh == 0) && (mv == 0);
            p = (mh == 0 && mv == 0) ? pat_sel_i : m_pat;
            s = (mh == 0 && mv == 0) ? solid_i : m_solid;
            if (o.dv) begin
                case (p)
                    2'd0: o.data = 8'(((mh / (HA / 8)) > 7 ? 7 : (mh / (HA / 8))) * 32);
                    2'd1: o.data = 8'(mh);
                    2'd2: o.data = ((((mh >> 4) ^ (mv >> 4)) & 1) != 0) ? 8'hFF : 8'h00;
                    default: o.data = s;
                endcase
            end
        end
        return o;
    endfunction

    task automatic model_update();
        int nxt;
        logic last;
        if (rst) begin
            m_state = 0; mh = 0; mv = 0; m_pat = 2'd0; m_solid = 8'd0;
        end else begin
            if (mh == 0 && mv == 0) begin
                m_pat = pat_sel_i;
                m_solid = solid_i;
            end
            last = (mh == HT - 1) && (mv == VT - 1);
            nxt = m_state;
            case (m_state)
                0: if (en_i) nxt = 1;
                1: if (!en_i) nxt = 2;
                default: if (en_i) nxt = 1; else if (last) nxt = 0;
            endcase
            if (m_state != 0) begin
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end
            end
            m_state = nxt;
        end
    endtask

    task automatic clear_stats();
        n_dv = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_le = 0; n_5a = 0; n_zero = 0;
        dv_first = -1; hs_first = -1; row_n = 0;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // One clock: predict, queue, clock, pop, compare, collect statistics.
    task automatic step();
        obs_t ex, act;
        exp_q.push_back(model_out());
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        act = {data_o, dv_o, hs_o, vs_o, line_end_o, frame_start_o, busy_o};
        ex = exp_q.pop_front();
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL outputs cyc=%0d got data=%02h dv=%b hs=%b vs=%b le=%b fs=%b busy=%b expected data=%02h dv=%b hs=%b vs=%b le=%b fs=%b busy=%b",
                     cyc, act.data, act.dv, act.hs, act.vs, act.le, act.fs, act.busy,
                     ex.data, ex.dv, ex.hs, ex.vs, ex.le, ex.fs, ex.busy);
        end
        if (dv_o) begin
            n_dv++;
            if (dv_first < 0) dv_first = cyc;
            if (row_n < 8) begin row[row_n] = data_o; row_n++; end
            if (data_o == 8'h5A) n_5a++;
            if (data_o == 8'h00) n_zero++;
        end
        if (hs_o) begin
            n_hs++;
            if (hs_first < 0) hs_first = cyc;
        end
        if (vs_o) n_vs++;
        if (line_end_o) n_le++;
        if (frame_start_o) begin
            n_fs++;
            fs_gap = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int k;
        vecs[0] = '{pat: 2'd0, solid: 8'h00, row: 64'hE0C0A08060402000};
        vecs[1] = '{pat: 2'd1, solid: 8'h00, row: 64'h0706050403020100};
        vecs[2] = '{pat: 2'd2, solid: 8'h00, row: 64'h0000000000000000};
        vecs[3] = '{pat: 2'd3, solid: 8'hC3, row: 64'hC3C3C3C3C3C3C3C3};

        rst = 1'b1; en_i = 1'b0; pat_sel_i = 2'd0; solid_i = 8'h00;
        run(3);
        check("reset_busy", int'(busy_o), 0);
        rst = 1'b0;
        run(2);
        en_i = 1'b1;
        step();                         // IDLE -> RUN, counters at 0,0

        // Table-driven: one full frame per pattern
        for (int i = 0; i < 4; i++) begin
            pat_sel_i = vecs[i].pat;
            solid_i = vecs[i].solid;
            clear_stats();
            run(FRAME);
            for (int p = 0; p < 8; p++)
                check($sformatf("row%0d_px%0d", i, p), int'(row[p]), int'(vecs[i].row[p*8 +: 8]));
            check("dv_count", n_dv, 32);
            check("hs_count", n_hs, 14);
            check("vs_count", n_vs, 14);
            check("fs_count", n_fs, 1);
            check("le_count", n_le, 4);
            check("hs_offset", hs_first - dv_first, 10);
            if (i > 0) check("frame_period", fs_gap, FRAME);
        end

        // Mid-frame pattern change: solid stays for this frame, checker next
        pat_sel_i = 2'd3; solid_i = 8'h5A;
        clear_stats();
        run(33);
        pat_sel_i = 2'd2;
        run(FRAME - 33);
        check("midframe_solid_px", n_5a, 32);
        clear_stats();
        run(FRAME);
        check("next_frame_5a_px", n_5a, 0);
        check("next_frame_checker_px", n_zero, 32);

        // Drain: en_i dropped in line 1, frame completes then goes idle
        pat_sel_i = 2'd1;
        clear_stats();
        run(17);
        en_i = 1'b0;
        k = 17;
        while (busy_o && k < 300) begin
            step();
            k++;
        end
        check("drain_busy_fall_cycle", k, FRAME + 1);
        check("drain_dv_count", n_dv, 32);
        check("drain_idle_data", int'(data_o), 0);
        run(5);

        // Re-run during drain: no gap between frames
        en_i = 1'b1;
        step();
        clear_stats();
        run(17);
        en_i = 1'b0;
        run(79);
        en_i = 1'b1;
        run(2);
        clear_stats();
        run(FRAME);
        check("no_gap_period", fs_gap, FRAME);
        check("no_gap_dv_count", n_dv, 32);

        // Reset at line 2 pixel 3
        clear_stats();
        run(31);
        rst = 1'b1;
        step();
        check("rst_dv", int'(dv_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        step();
        check("fs_1_after_rst", int'(frame_start_o), 0);
        step();
        check("fs_2_after_rst", int'(frame_start_o), 1);
        run(FRAME);
        check("post_rst_period", fs_gap, FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- COLORDEPTH, 8, pixel width
- H_ACTIVE, 1600, active pixels/line
- H_FP, 24, horizontal front porch
- H_SYNC, 80, hsync width
- H_BP, 96, horizontal back porch
- V_ACTIVE, 900, active lines/frame
- V_FP, 1, vertical front porch
- V_SYNC, 3, vsync width
- V_BP, 96, vertical back porch
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1, clock
- rst, in, 1, reset, synchronous, active-high
- en_i, in, 1, run request
- pat_sel_i, in, 2, pattern select
- solid_i, in, COLORDEPTH, solid-fill value
- data_o, out, COLORDEPTH, pixel
- dv_o, out, 1, data valid
- hs_o, out, 1, hsync (active-high)
- vs_o, out, 1, vsync (active-high)
- line_end_o, out, 1, last active pixel of line
- frame_start_o, out, 1, first active pixel of frame
- busy_o, out, 1, state != IDLE

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be elaboration-time constants; hcnt and vcnt SHALL be sized with $clog2 of these totals.
REQ-004 Line order SHALL be active, front porch, sync, back porch; frame order SHALL be the same in lines.
REQ-005 hcnt SHALL count 0..H_TOTAL-1 and wrap; vcnt SHALL increment when hcnt wraps and SHALL wrap 0 after V_TOTAL-1.
REQ-006 dv_o SHALL be set iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-007 hs_o SHALL be set iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, in every line, including blanking lines.
REQ-008 vs_o SHALL be set for all cycles of lines V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC-1.
REQ-009 line_end_o SHALL equal dv_o AND hcnt==H_ACTIVE-1; frame_start_o SHALL equal dv_o AND hcnt==0 AND vcnt==0.
REQ-010 All outputs SHALL be registered: each output reflects the counter state of the previous cycle (1-cycle latency), with all outputs mutually aligned.
REQ-011 Patterns SHALL be:
- 0: 8 colour bars; bar index 0..7 advances every H_ACTIVE/8 pixels, tracked by a counter (no divider); data = {idx, zeros}
- 1: ramp; data = hcnt[COLORDEPTH-1:0]
- 2: checker; data = all-ones when hcnt[4]^vcnt[4], else 0
- 3: solid; data = solid_i
REQ-012 pat_sel_i and solid_i SHALL be latched only at hcnt==0, vcnt==0; a mid-frame change SHALL take effect at the next frame.
REQ-013 data_o SHALL be 0 whenever dv_o=0.
REQ-014 The state machine SHALL have states IDLE, RUN and DRAIN:
- IDLE: en_i=1 -> RUN, with counters at 0,0
- RUN: en_i=0 -> DRAIN
- DRAIN: en_i=1 -> RUN, counting uninterrupted
- DRAIN: at the cycle hcnt=H_TOTAL-1, vcnt=V_TOTAL-1 -> IDLE
REQ-015 In IDLE, dv_o, hs_o, vs_o, line_end_o, frame_start_o and data_o SHALL be 0, and the counters SHALL be held at 0.
REQ-016 A frame in progress SHALL never be truncated by en_i deassertion; only rst aborts it.

Reset
REQ-017 On rst=1 the block SHALL enter IDLE, clear hcnt, vcnt and the bar counter, set all outputs 0, and latch pattern 0.
REQ-018 Reset mid-frame SHALL take effect at the next clk edge; the first frame after reset SHALL start at hcnt=0, vcnt=0.

Structure
REQ-019 The state enum and pattern-select encoding SHALL reside in the shared video package (video_pkg), alongside the shared COLORDEPTH default.
REQ-020 One sub-module, video_timing_cnt, SHALL implement the counters and the sync/dv/line_end decode; pattern generation and the state machine SHALL reside in the top.

Verification
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7).
REQ-021 Timing: rst, then en_i=1 held -> dv_o high 8 of every 14 cycles over 4 lines; hs_o high 2 cycles starting 10 cycles after each line's dv_o rise; vs_o high for 14 cycles, in line 5; frame period 98 cycles.
REQ-022 Ramp: pat_sel_i=1 -> data_o = 0,1,...,7 on every active line; line_end_o coincides with data_o=7; frame_start_o is set once per frame.
REQ-023 Bars: pat_sel_i=0 -> data_o = 0x00, 0x20, ..., 0xE0, one value per pixel.
REQ-024 Mid-frame change: pat_sel_i switched 3->2 during line 2, solid_i=0x5A -> remaining lines show 0x5A; the next frame shows the checker.
REQ-025 Drain: en_i dropped at line 1 -> frame completes all 98 cycles, then busy_o=0 and outputs 0; en_i re-asserted during DRAIN -> no gap between frames.
REQ-026 Reset mid-frame: rst pulsed at line 2, pixel 3 -> next cycle, all outputs are 0; with en_i=1, frame_start_o occurs 2 cycles after rst falls.
